// File: rtl/fdiv_param_if.sv
// Handshake and operand/result bundle for the MIX floating-point divider.
// master drives start/abort/operands; slave (the divider) returns status and result.
interface fdiv_param_if #(
  parameter int W = 31
);
  logic         start;
  logic         abort;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic         ovf;
  logic         unf;
  logic         dz;

  modport master (
    output start, abort, dividend, divisor,
    input  busy, done, quotient, ovf, unf, dz
  );

  modport slave (
    input  start, abort, dividend, divisor,
    output busy, done, quotient, ovf, unf, dz
  );
endinterface

// File: rtl/fdiv_param.sv
// Parametrised MIX floating-point divider: byte normalisation, radix-2^R digit
// recurrence (R quotient bits per cycle), round-to-nearest ties-away, ovf/unf/dz flags.
module fdiv_param #(
  parameter int BYTE_BITS  = 6,
  parameter int MANT_BYTES = 4,
  parameter int R          = 3   // (MANT_BYTES+2)*BYTE_BITS must be a multiple of R
) (
  input  logic           clk,
  input  logic           rst_n,
  fdiv_param_if.slave    io
);
  localparam int W   = 1 + (MANT_BYTES + 1) * BYTE_BITS;
  localparam int MB  = MANT_BYTES * BYTE_BITS;
  localparam int QB  = (MANT_BYTES + 2) * BYTE_BITS;
  localparam int NIT = QB / R;
  localparam int RW  = MB + R + 1;
  localparam int EW  = BYTE_BITS + 2;
  localparam int CW  = $clog2(NIT + 1);
  localparam int ND  = 1 << R;
  localparam logic [EW-1:0] BIAS = EW'(1 << (BYTE_BITS - 1));

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ITER, S_FIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    dvd_q, dvd_d, dvs_q, dvs_d;
  logic [MB-1:0]   ms_q, ms_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [QB-1:0]   quo_q, quo_d;
  logic [EW-1:0]   exp_q, exp_d;
  logic            sign_q, sign_d, dzero_q, dzero_d, szero_q, szero_d;
  logic [W-1:0]    quotient_q, quotient_d;
  logic            ovf_q, ovf_d, unf_q, unf_d, dz_q, dz_d, done_q, done_d;

  // Shift left by whole bytes until the top byte is nonzero, one exponent step per byte.
  function automatic void norm_op(input  logic [BYTE_BITS-1:0] e_in,
                                  input  logic [MB-1:0]        m_in,
                                  output logic [EW-1:0]        e_out,
                                  output logic [MB-1:0]        m_out);
    m_out = m_in;
    e_out = {2'b00, e_in};
    for (int i = 0; i < MANT_BYTES - 1; i++) begin
      if (m_out[MB-1 -: BYTE_BITS] == '0) begin
        m_out = m_out << BYTE_BITS;
        e_out = e_out - EW'(1);
      end
    end
  endfunction

  logic [EW-1:0] ed_n, es_n;
  logic [MB-1:0] md_n, ms_n;

  always_comb begin
    norm_op(dvd_q[W-2 -: BYTE_BITS], dvd_q[MB-1:0], ed_n, md_n);
    norm_op(dvs_q[W-2 -: BYTE_BITS], dvs_q[MB-1:0], es_n, ms_n);
  end

  // Digit selection: the quotient register also feeds the remaining dividend bits in at its top.
  logic [RW-1:0]   rem_sh, rem_new, sub_k;
  logic [RW-1:0]   mult_k [1:ND-1];
  logic [ND-1:1]   ge;
  logic [R-1:0]    digit;

  assign rem_sh = RW'({rem_q, quo_q[QB-1 -: R]});

  for (genvar gi = 1; gi < ND; gi++) begin : g_mult
    assign mult_k[gi] = RW'(ms_q) * RW'(gi);
    assign ge[gi]     = (rem_sh >= mult_k[gi]);
  end

  always_comb begin
    digit = '0;
    sub_k = '0;
    for (int k = 1; k < ND; k++) begin
      if (ge[k]) begin
        digit = R'(k);
        sub_k = mult_k[k];
      end
    end
    rem_new = rem_sh - sub_k;
  end

  // Final normalise and round; ties-away needs only the round bit, so sticky has no effect.
  logic            top_nz, rnd;
  logic [MB-1:0]   mant_raw, mant_fin;
  logic [MB:0]     mant_rnd;
  logic [EW-1:0]   e_f, e_fin;
  logic [W-1:0]    res;
  logic            res_ovf, res_unf, res_dz;

  always_comb begin
    top_nz = |quo_q[QB-1 -: BYTE_BITS];
    if (top_nz) begin
      mant_raw = quo_q[QB-1 -: MB];
      rnd      = quo_q[QB-MB-1];
      e_f      = exp_q + EW'(1);
    end else begin
      mant_raw = quo_q[QB-BYTE_BITS-1 -: MB];
      rnd      = quo_q[QB-BYTE_BITS-MB-1];
      e_f      = exp_q;
    end
    mant_rnd = {1'b0, mant_raw} + {{MB{1'b0}}, rnd};
    if (mant_rnd[MB]) begin
      mant_fin = MB'(1) << (MB - BYTE_BITS);
      e_fin    = e_f + EW'(1);
    end else begin
      mant_fin = mant_rnd[MB-1:0];
      e_fin    = e_f;
    end
    res     = {sign_q, e_fin[BYTE_BITS-1:0], mant_fin};
    res_ovf = ~e_fin[EW-1] & e_fin[BYTE_BITS];
    res_unf = 1'b0;
    res_dz  = 1'b0;
    if (szero_q) begin
      res     = {sign_q, {(W-1){1'b0}}};
      res_ovf = 1'b1;
      res_dz  = 1'b1;
    end else if (dzero_q) begin
      res     = {sign_q, {(W-1){1'b0}}};
      res_ovf = 1'b0;
    end else if (e_fin[EW-1]) begin
      res     = {sign_q, {(W-1){1'b0}}};
      res_ovf = 1'b1;
      res_unf = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    ms_d       = ms_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    dzero_d    = dzero_q;
    szero_d    = szero_q;
    quotient_d = quotient_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    dz_d       = dz_q;
    done_d     = 1'b0;
    if (io.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (io.start && !done_q) begin
            dvd_d   = io.dividend;
            dvs_d   = io.divisor;
            state_d = S_NORM;
          end
        end
        S_NORM: begin
          ms_d    = ms_n;
          rem_d   = RW'(md_n >> BYTE_BITS);
          quo_d   = {md_n[BYTE_BITS-1:0], {(QB-BYTE_BITS){1'b0}}};
          exp_d   = ed_n - es_n + BIAS;
          sign_d  = dvd_q[W-1] ^ dvs_q[W-1];
          dzero_d = (dvd_q[MB-1:0] == '0);
          szero_d = (dvs_q[MB-1:0] == '0);
          cnt_d   = '0;
          state_d = S_ITER;
        end
        S_ITER: begin
          rem_d = rem_new;
          quo_d = {quo_q[QB-R-1:0], digit};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(NIT - 1)) state_d = S_FIN;
        end
        S_FIN: begin
          quotient_d = res;
          ovf_d      = res_ovf;
          unf_d      = res_unf;
          dz_d       = res_dz;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      ms_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      dzero_q    <= 1'b0;
      szero_q    <= 1'b0;
      quotient_q <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      ms_q       <= ms_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      dzero_q    <= dzero_d;
      szero_q    <= szero_d;
      quotient_q <= quotient_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      dz_q       <= dz_d;
      done_q     <= done_d;
    end
  end

  // busy also covers the done cycle so a start there is ignored.
  assign io.busy     = (state_q != S_IDLE) | done_q;
  assign io.done     = done_q;
  assign io.quotient = quotient_q;
  assign io.ovf      = ovf_q;
  assign io.unf      = unf_q;
  assign io.dz       = dz_q;
endmodule

// File: tb/tb_fdiv_param.sv
// Randomised scoreboard bench for fdiv_param; expected results come from an
// exact-ratio integer model of the MIX divide rules.
module tb_fdiv_param;
  localparam int B     = 6;
  localparam int MBY   = 4;
  localparam int RR    = 3;
  localparam int W     = 1 + (MBY + 1) * B;
  localparam int MBITS = MBY * B;
  localparam int LAT   = (MBY + 2) * B / RR + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fdiv_param_if #(.W(W)) io ();
  fdiv_param #(.BYTE_BITS(B), .MANT_BYTES(MBY), .R(RR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic         ovf;
    logic         unf;
    logic         dz;
    int           t0;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_err    = 0;
  int           n_txn    = 0;
  int           cyc      = 0;
  logic [W-1:0] last_q   = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Value model: result = (md/ms) * b^(ed-es), mantissa chosen so its top byte is nonzero.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   r;
    longint ma, mb, m;
    int     ea, eb, e;
    logic   s;
    s = a[W-1] ^ b[W-1];
    ma = longint'(a[MBITS-1:0]);
    mb = longint'(b[MBITS-1:0]);
    ea = int'(a[W-2 -: B]);
    eb = int'(b[W-2 -: B]);
    r.a = a; r.b = b; r.t0 = 0;
    r.ovf = 1'b0; r.unf = 1'b0; r.dz = 1'b0;
    r.q = {s, {(W-1){1'b0}}};
    if (mb == 0) begin
      r.ovf = 1'b1;
      r.dz  = 1'b1;
      return r;
    end
    if (ma == 0) return r;
    while (ma < (longint'(1) << (MBITS - B))) begin ma = ma << B; ea--; end
    while (mb < (longint'(1) << (MBITS - B))) begin mb = mb << B; eb--; end
    e = ea - eb + (1 << (B - 1));
    if (ma >= mb) begin
      m = ((ma << (MBITS - B + 1)) + mb) / (2 * mb);
      e++;
    end else begin
      m = ((ma << (MBITS + 1)) + mb) / (2 * mb);
    end
    if (m == (longint'(1) << MBITS)) begin
      m = longint'(1) << (MBITS - B);
      e++;
    end
    if (e < 0) begin
      r.ovf = 1'b1;
      r.unf = 1'b1;
      return r;
    end
    r.ovf = (e >= (1 << B));
    r.q   = {s, B'(e % (1 << B)), MBITS'(m)};
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [MBITS-1:0] m;
    int               k;
    k = $urandom_range(0, 9);
    m = MBITS'($urandom);
    if (k == 0) m = '0;
    else if (k < 4) m = m >> (B * $urandom_range(1, MBY - 1));
    else if (m[MBITS-1 -: B] == '0) m[MBITS-1] = 1'b1;
    return {1'($urandom_range(0, 1)), B'($urandom_range(0, (1 << B) - 1)), m};
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (io.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", longint'(io.busy), 0);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
    exp_t e;
    wait_idle();
    io.dividend = a;
    io.divisor  = b;
    io.start    = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
    chk("busy_after_start", longint'(io.busy), 1);
    if (track) begin
      e    = model(a, b);
      e.t0 = cyc;
      sb.push_back(e);
    end
  endtask

  // Monitor: pops the scoreboard whenever done is seen.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && io.done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending result", cyc);
        end else begin
          e = sb.pop_front();
          chk("quotient", longint'(io.quotient), longint'(e.q));
          chk("ovf", longint'(io.ovf), longint'(e.ovf));
          chk("unf", longint'(io.unf), longint'(e.unf));
          chk("dz", longint'(io.dz), longint'(e.dz));
          chk("latency", longint'(cyc - e.t0), LAT);
          last_q = e.q;
          n_txn++;
          $display("txn %0d: %o / %o -> %o ovf=%0d unf=%0d dz=%0d (cycle %0d)",
                   n_txn, e.a, e.b, io.quotient, io.ovf, io.unf, io.dz, cyc - e.t0);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by time limit, expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] da [8];
    logic [W-1:0] db [8];
    int           n;
    da[0] = {1'b0, 6'o41, 24'o01000000}; db[0] = {1'b0, 6'o41, 24'o01000000};
    da[1] = {1'b0, 6'o41, 24'o01000000}; db[1] = {1'b0, 6'o41, 24'o03000000};
    da[2] = {1'b0, 6'o41, 24'o02000000}; db[2] = {1'b1, 6'o41, 24'o03000000};
    da[3] = {1'b0, 6'o77, 24'o01000000}; db[3] = {1'b0, 6'o01, 24'o01000000};
    da[4] = {1'b0, 6'o00, 24'o01000000}; db[4] = {1'b0, 6'o77, 24'o01000000};
    da[5] = {1'b0, 6'o41, 24'o01000000}; db[5] = {1'b1, 6'o23, 24'o00000000};
    da[6] = {1'b1, 6'o10, 24'o00000000}; db[6] = {1'b0, 6'o41, 24'o03000000};
    da[7] = {1'b0, 6'o40, 24'o00001234}; db[7] = {1'b1, 6'o42, 24'o00770000};

    io.start = 1'b0; io.abort = 1'b0; io.dividend = '0; io.divisor = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", longint'(io.busy), 0);
    chk("rst_done", longint'(io.done), 0);
    chk("rst_quotient", longint'(io.quotient), 0);
    chk("rst_ovf", longint'(io.ovf), 0);
    chk("rst_unf", longint'(io.unf), 0);
    chk("rst_dz", longint'(io.dz), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) issue(da[i], db[i], 1'b1);

    // A start while busy must neither restart nor queue a second operation.
    issue(da[2], db[2], 1'b1);
    repeat (4) @(negedge clk);
    io.dividend = da[3]; io.divisor = db[3]; io.start = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
    chk("held_quotient", longint'(io.quotient), longint'(last_q));

    // Abort sampled on the fifth edge after start.
    issue(da[1], db[1], 1'b0);
    repeat (4) @(negedge clk);
    io.abort = 1'b1;
    @(negedge clk);
    io.abort = 1'b0;
    chk("abort_busy", longint'(io.busy), 0);
    chk("abort_done", longint'(io.done), 0);
    repeat (20) @(negedge clk);
    chk("abort_held", longint'(io.quotient), longint'(last_q));

    // Asynchronous reset in the middle of an operation.
    issue(da[3], db[3], 1'b1);
    wait_idle();
    issue(da[0], db[1], 1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", longint'(io.busy), 0);
    chk("rst_mid_quotient", longint'(io.quotient), 0);
    chk("rst_mid_ovf", longint'(io.ovf), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    last_q = '0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 40; i++) issue(rnd_op(), rnd_op(), 1'b1);

    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", longint'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
